// File: rtl/rev_counter_n_if.sv
// rev_counter_n bus: control inputs (en, s, load, din) toward the counter,
// count and status (cnt, Rc, tick, wrap) back from it.
interface rev_counter_n_if #(
  parameter int W = 16
);
  logic         en;
  logic         s;
  logic         load;
  logic [W-1:0] din;
  logic [W-1:0] cnt;
  logic         Rc;
  logic         tick;
  logic         wrap;

  modport master (
    output en, s, load, din,
    input  cnt, Rc, tick, wrap
  );

  modport slave (
    input  en, s, load, din,
    output cnt, Rc, tick, wrap
  );
endinterface

// File: rtl/rev_counter_n.sv
// Reversible binary/BCD counter with built-in step prescaler.
// Ports: clk, RST (sync, active-high), bus (slave: en s load din / cnt Rc tick wrap).
module rev_counter_n #(
  parameter int DIGITS   = 4,
  parameter bit BCD      = 1'b0,
  parameter int PRESCALE = 10_000_000
) (
  input  logic           clk,
  input  logic           RST,
  rev_counter_n_if.slave bus
);
  localparam int W  = 4 * DIGITS;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [PW-1:0] p;
  logic [W-1:0]  count;
  logic          tick_q;
  logic          wrap_q;

  logic [W-1:0]  bcd_nxt;
  logic          bcd_c;
  logic          nine;
  logic [3:0]    nib;

  logic [W-1:0]  nxt;
  logic          nxt_wrap;
  logic          at_max;
  logic          step;

  // Ripple carry/borrow through the nibbles. Up: any nibble >= 9
  // (including A-F) rolls to 0 and carries. Down: 0 rolls to 9 and
  // borrows; A-F simply decrement.
  always_comb begin
    bcd_nxt = count;
    bcd_c   = 1'b1;
    nine    = 1'b1;
    nib     = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      nib  = count[4*i +: 4];
      nine = nine & (nib == 4'd9);
      if (bcd_c) begin
        if (!bus.s) begin
          if (nib >= 4'd9) begin
            bcd_nxt[4*i +: 4] = 4'd0;
          end else begin
            bcd_nxt[4*i +: 4] = nib + 4'd1;
            bcd_c = 1'b0;
          end
        end else begin
          if (nib == 4'd0) begin
            bcd_nxt[4*i +: 4] = 4'd9;
          end else begin
            bcd_nxt[4*i +: 4] = nib - 4'd1;
            bcd_c = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    nxt      = count;
    nxt_wrap = 1'b0;
    at_max   = 1'b0;
    if (BCD) begin
      nxt      = bcd_nxt;
      nxt_wrap = bcd_c;
      at_max   = nine;
    end else begin
      nxt      = bus.s ? count - W'(1) : count + W'(1);
      nxt_wrap = bus.s ? (count == '0) : (&count);
      at_max   = &count;
    end
  end

  assign step = bus.en && (p == PMAX);

  always_ff @(posedge clk) begin
    if (RST) begin
      count  <= '0;
      p      <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else if (bus.load) begin
      count  <= bus.din;
      p      <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      if (step) begin
        p      <= '0;
        count  <= nxt;
        tick_q <= 1'b1;
        wrap_q <= nxt_wrap;
      end else if (bus.en) begin
        p <= p + PW'(1);
      end
    end
  end

  assign bus.cnt  = count;
  assign bus.tick = tick_q;
  assign bus.wrap = wrap_q;
  assign bus.Rc   = bus.s ? (count == '0) : at_max;
endmodule

// File: doc/rev_counter_n.md
# rev_counter_n

Parametrised up/down counter that generalises the board-level reversible counter: configurable digit count, binary or BCD counting, a built-in step prescaler that removes the need for an external slow clock, synchronous parallel load, count enable, and terminal/wrap status for cascading. It runs on the system clock and feeds the 7-segment display driver directly through `cnt`. The count advances only on prescaler steps.

## Interface
- `DIGITS`, 4: number of 4-bit nibbles; count width W = 4*DIGITS.
- `BCD`, 0: 0 = binary count over W bits; 1 = each nibble counts decimal 0..9.
- `PRESCALE`, 10_000_000: clk cycles per count step, ≥1; 1 = step every enabled cycle.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `en`  in  1  count enable; gates both the prescaler and stepping.
- `s`  in  1  direction: 0 = up, 1 = down.
- `load`  in  1  synchronous parallel load strobe.
- `din`  in  W  load value.
- `cnt`  out  W  current count, registered.
- `Rc`  out  1  terminal count, combinational from `cnt` and `s`.
- `tick`  out  1  registered one-cycle pulse, high in the cycle `cnt` shows a newly stepped value.
- `wrap`  out  1  registered one-cycle pulse, high with `tick` when that step wrapped around.

## Operation
- Priority per edge: `RST` > `load` > step > hold.
- Reset: `cnt`=0, prescaler=0, `tick`=0, `wrap`=0. After reset, `Rc` follows its rule (1 if `s`=1, since `cnt`=0).
- Prescaler: counter p in 0..PRESCALE-1. It advances only while `en`=1 and freezes while `en`=0 (no clear). A step occurs on the edge where `en`=1 and p=PRESCALE-1; p then returns to 0. Width is ceil(log2(PRESCALE)), minimum 1 bit.
- `load`=1: `cnt`←`din`, p←0, `tick`=`wrap`=0. Load works regardless of `en`.
- Step, binary: up `cnt`+1 mod 2^W, down `cnt`-1 mod 2^W. `wrap` when going up from all-ones, or down from 0.
- Step, BCD, up: the lowest nibble increments. A nibble ≥9 becomes 0 and carries into the next nibble. Carry out of the top nibble is a wrap, so all-9s becomes 0.
- Step, BCD, down: the lowest nibble decrements. A nibble equal to 0 becomes 9 and borrows. Borrow out of the top nibble is a wrap, so 0 becomes all-9s.
- Non-decimal nibbles (A–F) loaded in BCD mode: up treats them as ≥9 (→0 with carry). Down decrements them by 1 without borrow. No error flag.
- `Rc`: `s`=0 → high when `cnt` is the maximum (binary all-ones; BCD all nibbles 9). `s`=1 → high when `cnt`=0. `Rc` is not gated by `en`.
- Direction change takes effect on the next step. The prescaler phase is unaffected.
- No step in a cycle: `tick`=`wrap`=0, `cnt` holds.

## Timing
- Step latency: `cnt`, `tick` and `wrap` update on the same edge where p=PRESCALE-1 and `en`=1. They are visible in the following cycle.
- Steady `en`=1: exactly one `tick` per PRESCALE cycles. The first tick comes PRESCALE edges after reset or load.
- `RST` or `load` in a step cycle: the step is discarded, with no `tick` and no `wrap`.
- `en` dropped mid-period: p holds. When `en` is reasserted, the remaining cycles are counted, not restarted.
- `Rc` changes combinationally with `s` in the same cycle.
- PRESCALE=1: a step occurs every cycle with `en`=1, and `tick` mirrors `en` delayed by one cycle (absent load/reset).

## Test plan
- Reset, binary, DIGITS=4, PRESCALE=4, `s`=0, `en`=1: `cnt`=0000. `tick` first appears 4 cycles after `RST` drops, with `cnt`=0001. The next tick arrives exactly 4 cycles later, with `cnt`=0002.
- Binary wrap, PRESCALE=1: load FFFE with `s`=0, then 2 steps gives FFFF (`Rc`=1), then 0000 with `wrap`=1. Switch to `s`=1: `Rc`=1 in the same cycle. The next step gives FFFF with `wrap`=1.
- BCD, DIGITS=2, PRESCALE=1: load 0x98 with `s`=0. Steps give 0x99 (`Rc`=1), then 0x00 with `wrap`. With `s`=1 from 0x10, the next step gives 0x09 and then 0x08, with no `wrap`.
- BCD, invalid nibble: load 0x0C with `s`=0, and one step gives 0x10. Load 0x0C with `s`=1, and one step gives 0x0B.
- Enable freeze, PRESCALE=4: `en`=1 for 2 cycles, `en`=0 for 10 cycles, then `en`=1. `tick` occurs after exactly 2 more enabled cycles, and `cnt` is unchanged during the pause.
- Priority: assert `load` (`din`=0x1234) in the cycle p=PRESCALE-1. Result: `cnt`=1234, `tick`=0, and the next tick comes PRESCALE cycles later. `RST` asserted together with `load` gives `cnt`=0.
